// File: rtl/aim_pos_decoder.sv
// aim_pos_decoder: snapshots the AIM per-entry valid/pos vectors on i_start,
// then streams the valid entries lowest index first on a valid/ready
// interface. Each 9-bit pos is split back into (group, lane), and an optional
// one-hot lane mask is produced.
// Optional feature macro: AIM_DEC_ONEHOT_EN (one-hot lane decoder on o_onehot).
module aim_pos_decoder #(
  parameter int unsigned N_ENTRY = 32,
  parameter int unsigned POS_W   = 9,
  parameter int unsigned LANE_W  = 5
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_start,
  input  logic [N_ENTRY-1:0]             i_valid,
  input  logic [N_ENTRY*POS_W-1:0]       i_pos,
  output logic                           o_busy,
  output logic                           o_out_valid,
  input  logic                           i_out_ready,
  output logic [$clog2(N_ENTRY)-1:0]     o_idx,
  output logic [POS_W-LANE_W-1:0]        o_group,
  output logic [LANE_W-1:0]              o_lane,
  output logic [(1<<LANE_W)-1:0]         o_onehot,
  output logic [$clog2(N_ENTRY+1)-1:0]   o_count,
  output logic                           o_done
);

  localparam int unsigned IDX_W = $clog2(N_ENTRY);
  localparam int unsigned CNT_W = $clog2(N_ENTRY + 1);
  localparam logic [N_ENTRY-1:0] ONE_BIT = {{(N_ENTRY-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_EMIT,
    S_DONE
  } state_t;

  state_t                     state_q;
  state_t                     state_d;
  logic [N_ENTRY-1:0]         mask_r;
  logic [N_ENTRY*POS_W-1:0]   pos_r;

  logic                       handshake;
  logic [N_ENTRY-1:0]         mask_clr;
  logic [N_ENTRY-1:0]         search;
  logic                       pick_found;
  logic [IDX_W-1:0]           pick_idx;
  logic [POS_W-1:0]           pick_pos;
  logic                       load_beat;

  // Priority-encode the lowest pending entry: in LOAD from the fresh
  // snapshot, in EMIT from the mask with the beat being accepted removed.
  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    handshake  = o_out_valid & i_out_ready;
    mask_clr   = mask_r & ~(ONE_BIT << o_idx);
    search     = (state_q == S_LOAD) ? mask_r : mask_clr;
    pick_found = |search;
    pick_idx   = '0;
    for (int i = N_ENTRY - 1; i >= 0; i--) begin
      if (search[i]) pick_idx = IDX_W'(i);
    end
    pick_pos  = pos_r[pick_idx*POS_W +: POS_W];
    load_beat = pick_found &&
                ((state_q == S_LOAD) || (state_q == S_EMIT && handshake));
  end

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (i_rst) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (i_start) state_d = S_LOAD;
      S_LOAD: state_d = pick_found ? S_EMIT : S_DONE;
      S_EMIT: if (handshake && !pick_found) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Snapshot, beat registers, accepted-beat counter and status flags.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      // NOTE: the snapshot registers are reset too, so a stale batch can never
      // leak into the next one after an abort.
      mask_r      <= '0;
      pos_r       <= '0;
      o_busy      <= 1'b0;
      o_out_valid <= 1'b0;
      o_idx       <= '0;
      o_group     <= '0;
      o_lane      <= '0;
      o_count     <= '0;
      o_done      <= 1'b0;
    end else begin
      o_done <= 1'b0;
      if (load_beat) begin
        o_idx   <= pick_idx;
        o_group <= pick_pos[POS_W-1:LANE_W];
        o_lane  <= pick_pos[LANE_W-1:0];
      end
      case (state_q)
        S_IDLE: begin
          if (i_start) begin
            mask_r  <= i_valid;
            pos_r   <= i_pos;
            o_count <= '0;
            o_busy  <= 1'b1;
          end
        end
        S_LOAD: begin
          if (pick_found) o_out_valid <= 1'b1;
        end
        S_EMIT: begin
          if (handshake) begin
            mask_r  <= mask_clr;
            o_count <= o_count + CNT_W'(1);
            if (!pick_found) o_out_valid <= 1'b0;
          end
        end
        S_DONE: begin
          o_done <= 1'b1;
          o_busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef AIM_DEC_ONEHOT_EN
  // One-hot lane mask, registered alongside the other beat fields.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)          o_onehot <= '0;
    else if (load_beat) o_onehot <= (1<<LANE_W)'(1) << pick_pos[LANE_W-1:0];
  end
`else
  // Decoder not built: lane mask is constant zero.
  assign o_onehot = '0;
`endif

endmodule

// File: tb/tb_aim_pos_decoder.sv
// Self-checking bench for aim_pos_decoder: directed and randomized batches
// checked against an event-level model (ordered queue of pending entries).
module tb_aim_pos_decoder;

  localparam int N  = 32;
  localparam int PW = 9;
  localparam int LW = 5;

  logic            i_clk = 1'b0;
  logic            i_rst = 1'b1;
  logic            i_start = 1'b0;
  logic [N-1:0]    i_valid = '0;
  logic [N*PW-1:0] i_pos = '0;
  logic            i_out_ready = 1'b0;
  logic            o_busy, o_out_valid, o_done;
  logic [4:0]      o_idx;
  logic [3:0]      o_group;
  logic [4:0]      o_lane;
  logic [31:0]     o_onehot;
  logic [5:0]      o_count;

  int vectors = 0;
  int miscompares = 0;

  aim_pos_decoder dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_valid(i_valid),
    .i_pos(i_pos), .o_busy(o_busy), .o_out_valid(o_out_valid),
    .i_out_ready(i_out_ready), .o_idx(o_idx), .o_group(o_group),
    .o_lane(o_lane), .o_onehot(o_onehot), .o_count(o_count), .o_done(o_done)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  function automatic logic [N*PW-1:0] rand_pos();
    logic [N*PW-1:0] r;
    for (int k = 0; k < PW; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [31:0] exp_onehot(input logic [4:0] lane);
`ifdef AIM_DEC_ONEHOT_EN
    return 32'h1 << lane;
`else
    return (lane == 5'd0) ? 32'h0 : 32'h0;
`endif
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"},  64'(o_out_valid), 64'(0));
    check({tag, "_busy"},   64'(o_busy),      64'(0));
    check({tag, "_done"},   64'(o_done),      64'(0));
    check({tag, "_count"},  64'(o_count),     64'(0));
    check({tag, "_idx"},    64'(o_idx),       64'(0));
    check({tag, "_group"},  64'(o_group),     64'(0));
    check({tag, "_lane"},   64'(o_lane),      64'(0));
    check({tag, "_onehot"}, 64'(o_onehot),    64'(0));
  endtask

  // ready_mode: 0 always ready, 1 toggling, 2 random.
  // poke bit0: i_start with other data during EMIT; bit1: i_start in DONE cycle.
  // abort_at > 0: assert reset right after that edge and stop the batch.
  task automatic run_batch(input logic [N-1:0] valid, input logic [N*PW-1:0] pos,
                           input int ready_mode, input int poke, input int abort_at);
    int q[$];
    bit vis;
    bit rdy;
    int cnt;
    int done_edge;
    logic [PW-1:0] p;
    for (int e = 0; e < N; e++) if (valid[e]) q.push_back(e);
    i_valid = valid;
    i_pos   = pos;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    i_valid = $urandom;
    i_pos   = rand_pos();
    check("start_busy",  64'(o_busy),      64'(1));
    check("start_valid", 64'(o_out_valid), 64'(0));
    check("start_count", 64'(o_count),     64'(0));
    vis = 1'b0;
    cnt = 0;
    done_edge = -1;
    for (int n = 1; n <= 300; n++) begin
      case (ready_mode)
        0:       rdy = 1'b1;
        1:       rdy = n[0];
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      i_out_ready = rdy;
      if (poke[0] && n == 3) begin
        i_start = 1'b1;
        i_valid = ~valid;
        i_pos   = rand_pos();
      end
      if (poke[1] && n == done_edge) begin
        i_start = 1'b1;
        i_valid = 32'hFFFF_FFFF;
      end
      tick();
      i_start = 1'b0;
      // Model: first beat appears one edge after capture; a visible beat
      // with ready at an edge is consumed; o_done follows one edge after the
      // final acceptance (or at edge 2 for an empty batch).
      if (n == 1) begin
        vis = (q.size() > 0);
        if (!vis) done_edge = 2;
      end else if (vis && rdy) begin
        void'(q.pop_front());
        cnt++;
        if (q.size() == 0) begin
          vis = 1'b0;
          done_edge = n + 1;
        end
      end
      if (abort_at == n) begin
        i_rst = 1'b1;
        #1;
        check_all_zero("abort");
        tick();
        tick();
        i_rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
          tick();
          check("abort_no_done", 64'(o_done), 64'(0));
          check("abort_idle",    64'(o_busy), 64'(0));
        end
        return;
      end
      check("out_valid", 64'(o_out_valid), 64'(vis));
      if (vis) begin
        p = pos[q[0]*PW +: PW];
        check("idx",    64'(o_idx),    64'(q[0]));
        check("group",  64'(o_group),  64'(p[8:5]));
        check("lane",   64'(o_lane),   64'(p[4:0]));
        check("onehot", 64'(o_onehot), 64'(exp_onehot(p[4:0])));
      end
      check("count", 64'(o_count), 64'(cnt));
      check("done",  64'(o_done),  64'(n == done_edge));
      check("busy",  64'(o_busy),  64'(done_edge < 0 || n < done_edge));
      if (done_edge > 0 && n == done_edge + 1) return;
    end
    vectors++;
    miscompares++;
    $error("FAIL batch_timeout: observed no o_done expected o_done within 300 cycles");
  endtask

  initial begin
    logic [N*PW-1:0] pos;
    // Reset state.
    #12;
    check_all_zero("reset");
    tick();
    i_rst = 1'b0;
    tick();
    check_all_zero("post_reset");

    // Two entries, always ready: (0,1,3,0x8) then (2,2,1,0x2).
    pos = rand_pos();
    pos[0*PW +: PW] = 9'h023;
    pos[2*PW +: PW] = 9'h041;
    run_batch(32'h0000_0005, pos, 0, 0, 0);

    // Empty batch; i_start in the DONE cycle is ignored.
    run_batch(32'h0, rand_pos(), 0, 2, 0);

    // Full batch with ready toggling: stalls must hold fields.
    run_batch(32'hFFFF_FFFF, rand_pos(), 1, 0, 0);

    // i_start during EMIT with different data is ignored.
    run_batch($urandom | 32'h0000_0101, rand_pos(), 2, 1, 0);

    // Reset mid-EMIT, then a clean batch.
    run_batch(32'hFFFF_FFFF, rand_pos(), 2, 0, 6);
    run_batch($urandom, rand_pos(), 2, 0, 0);

    // Randomized batches, including a sparse and a top-entry-only case.
    run_batch(32'h8000_0000, rand_pos(), 2, 0, 0);
    for (int b = 0; b < 6; b++) begin
      run_batch($urandom & $urandom, rand_pos(), 2, 3, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
